root_rank_ctrl: RTL

Controller at the root node that sequences the root rank register bank (2**RANK_WIDTH entries of DATA_WIDTH bits, synchronous write, combinational read gated by read enable). Per job it runs three phases: clear the active entries, accumulate partial V results from two child links, then stream the merged ranks to the downstream broadcast path. The two children share the bank's single write port through round-robin arbitration. Each accumulate is a one-cycle read-modify-write.

---
 rtl/root_rank_ctrl_if.sv | 60 ++++++
 rtl/root_rank_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/root_rank_ctrl_if.sv
// root_rank_ctrl_if -- bundles every non-clock/reset signal of root_rank_ctrl.
//   job control : start, rank_num, accum_done, busy, done
//   child links : in0_*/in1_* (valid, addr, data -> ready)
//   out stream  : out_valid, out_addr, out_data <- out_ready
//   bank port   : rank_we/waddr/wdata, rank_re/raddr -> rank_rdata
//   sat_flag    : only present when RANK_ACC_SATURATE_EN is defined
// Modports: master = the controller, slave = children, downstream and bank.
interface root_rank_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int RANK_WIDTH = 4
);
  logic                  start;
  logic [RANK_WIDTH:0]   rank_num;
  logic                  accum_done;
  logic                  in0_valid;
  logic [RANK_WIDTH-1:0] in0_addr;
  logic [DATA_WIDTH-1:0] in0_data;
  logic                  in0_ready;
  logic                  in1_valid;
  logic [RANK_WIDTH-1:0] in1_addr;
  logic [DATA_WIDTH-1:0] in1_data;
  logic                  in1_ready;
  logic                  out_valid;
  logic [RANK_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic                  rank_we;
  logic [RANK_WIDTH-1:0] rank_waddr;
  logic [DATA_WIDTH-1:0] rank_wdata;
  logic                  rank_re;
  logic [RANK_WIDTH-1:0] rank_raddr;
  logic [DATA_WIDTH-1:0] rank_rdata;
`ifdef RANK_ACC_SATURATE_EN
  logic                  sat_flag;
`endif

  modport master (
    input  start, rank_num, accum_done,
    input  in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
    input  out_ready, rank_rdata,
`ifdef RANK_ACC_SATURATE_EN
    output sat_flag,
`endif
    output in0_ready, in1_ready, out_valid, out_addr, out_data, busy, done,
    output rank_we, rank_waddr, rank_wdata, rank_re, rank_raddr
  );

  modport slave (
    output start, rank_num, accum_done,
    output in0_valid, in0_addr, in0_data, in1_valid, in1_addr, in1_data,
    output out_ready, rank_rdata,
`ifdef RANK_ACC_SATURATE_EN
    input  sat_flag,
`endif
    input  in0_ready, in1_ready, out_valid, out_addr, out_data, busy, done,
    input  rank_we, rank_waddr, rank_wdata, rank_re, rank_raddr
  );
endinterface

// File: rtl/root_rank_ctrl.sv
// root_rank_ctrl -- sequences the root rank bank through CLEAR, ACCUM and
// DRAIN for one job. Two child links share the bank write port through a
// round-robin arbiter; each accepted beat is a single-cycle read-modify-write.
// Ports: clk, rst (asynchronous, active-high), bus (root_rank_ctrl_if.master).
// Optional: define RANK_ACC_SATURATE_EN for saturating accumulation and the
// sticky sat_flag output; otherwise sums wrap in two's complement.
module root_rank_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int RANK_WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  root_rank_ctrl_if.master   bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  localparam logic [RANK_WIDTH:0] NUM_FULL = {1'b1, {RANK_WIDTH{1'b0}}};
  localparam logic [RANK_WIDTH:0] NUM_ONE  = {{RANK_WIDTH{1'b0}}, 1'b1};

  state_t                state_reg;
  logic [RANK_WIDTH-1:0] cnt_reg;
  logic                  rr_ptr_reg;
  logic [RANK_WIDTH:0]   num_q_reg;
  logic                  accum_pend_reg;

  logic                  grant_any;
  logic                  grant_id;
  logic                  both_valid;
  logic [RANK_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  in_range;
  logic                  last_cnt;
  logic [DATA_WIDTH-1:0] acc_sum;

  assign both_valid = bus.in0_valid && bus.in1_valid;

  // Round-robin only matters when both children compete; a lone valid child
  // always wins and leaves the pointer alone.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state_reg == ACCUM) begin
      if (both_valid) begin
        grant_any = 1'b1;
        grant_id  = rr_ptr_reg;
      end else if (bus.in0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.in1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign g_addr   = grant_id ? bus.in1_addr : bus.in0_addr;
  assign g_data   = grant_id ? bus.in1_data : bus.in0_data;
  // Beats aimed beyond the active ranks are consumed but never written.
  assign in_range = ({1'b0, g_addr} < num_q_reg);
  assign last_cnt = ({1'b0, cnt_reg} == (num_q_reg - NUM_ONE));

`ifdef RANK_ACC_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic [DATA_WIDTH:0] sum_wide;
  logic                sat_hi;
  logic                sat_lo;
  logic                sat_flag_reg;

  // Sign-extended sum; the top two bits disagree exactly on overflow.
  assign sum_wide = {bus.rank_rdata[DATA_WIDTH-1], bus.rank_rdata}
                  + {g_data[DATA_WIDTH-1], g_data};
  assign sat_hi   = !sum_wide[DATA_WIDTH] &&  sum_wide[DATA_WIDTH-1];
  assign sat_lo   =  sum_wide[DATA_WIDTH] && !sum_wide[DATA_WIDTH-1];
  assign acc_sum  = sat_hi ? SAT_MAX : (sat_lo ? SAT_MIN : sum_wide[DATA_WIDTH-1:0]);
  assign bus.sat_flag = sat_flag_reg;
`else
  assign acc_sum = bus.rank_rdata + g_data;
`endif

  // Bank port is purely a function of state, counter and grant.
  always_comb begin
    bus.rank_we    = 1'b0;
    bus.rank_waddr = '0;
    bus.rank_wdata = '0;
    bus.rank_re    = 1'b0;
    bus.rank_raddr = '0;
    case (state_reg)
      CLEAR: begin
        bus.rank_we    = 1'b1;
        bus.rank_waddr = cnt_reg;
      end
      ACCUM: begin
        if (grant_any) begin
          bus.rank_re    = 1'b1;
          bus.rank_raddr = g_addr;
          if (in_range) begin
            bus.rank_we    = 1'b1;
            bus.rank_waddr = g_addr;
            bus.rank_wdata = acc_sum;
          end
        end
      end
      DRAIN: begin
        bus.rank_re    = 1'b1;
        bus.rank_raddr = cnt_reg;
      end
      default: ;
    endcase
  end

  assign bus.in0_ready = grant_any && !grant_id;
  assign bus.in1_ready = grant_any &&  grant_id;
  assign bus.out_valid = (state_reg == DRAIN);
  assign bus.out_addr  = (state_reg == DRAIN) ? cnt_reg : '0;
  assign bus.out_data  = (state_reg == DRAIN) ? bus.rank_rdata : '0;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DRAIN) && bus.out_ready && last_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rr_ptr_reg     <= 1'b0;
      num_q_reg      <= '0;
      accum_pend_reg <= 1'b0;
`ifdef RANK_ACC_SATURATE_EN
      sat_flag_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg      <= CLEAR;
            cnt_reg        <= '0;
            accum_pend_reg <= 1'b0;
            // A count of zero means a full bank.
            num_q_reg      <= (bus.rank_num == '0) ? NUM_FULL : bus.rank_num;
`ifdef RANK_ACC_SATURATE_EN
            sat_flag_reg   <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          if (last_cnt) begin
            state_reg <= ACCUM;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ACCUM: begin
          if (bus.accum_done) accum_pend_reg <= 1'b1;
          if (both_valid) rr_ptr_reg <= ~rr_ptr_reg;
`ifdef RANK_ACC_SATURATE_EN
          if (grant_any && in_range && (sat_hi || sat_lo)) sat_flag_reg <= 1'b1;
`endif
          // Pending beats drain before leaving, even alongside accum_done.
          if ((accum_pend_reg || bus.accum_done) && !bus.in0_valid && !bus.in1_valid) begin
            state_reg      <= DRAIN;
            cnt_reg        <= '0;
            accum_pend_reg <= 1'b0;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (last_cnt) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
